master_clock_supervisor: RTL and testbench

Lock supervisor on the consuming side of master_clock. It runs on the free-running 50 MHz reference and drives the PLL's reset input, then watches its locked output. It qualifies lock over a stability window before releasing the system reset. It also handles lock loss, timed-out lock attempts with bounded retries, and reports status to the CPC core and the debug registers.

---
 rtl/master_clock_supervisor.sv | 144 ++++++++++++++
 tb/tb_master_clock_supervisor.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/master_clock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : master_clock_supervisor
// Brief    : Pulses the PLL reset, qualifies lock over a stability window,
//            then releases system reset; handles loss, timeout and retries.
// Revision : 1.0 - initial release
// ============================================================================
module master_clock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 17
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       retry,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       pll_ok,
    output logic       fail,
    output logic [7:0] loss_count,
    output logic [2:0] state
);

    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   c_rst_last     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_stable_last  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_timeout_last = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] c_max_retries  = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_nxt_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_nxt_cnt;
    logic [RETRY_W-1:0] r_retries;
    logic [RETRY_W-1:0] w_nxt_retries;
    logic [7:0]         w_nxt_loss;
    logic               r_sync1;
    logic               r_sync2;
    logic               w_locked_s;

    assign w_locked_s = r_sync2;
    assign state      = r_state;

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_cnt     = '0;
        w_nxt_retries = r_retries;
        w_nxt_loss    = loss_count;
        // A retry request pre-empts every other transition except in RESET_PLL.
        if (retry && (r_state != S_RESET_PLL)) begin
            w_nxt_state   = S_RESET_PLL;
            w_nxt_retries = '0;
        end else begin
            case (r_state)
                S_RESET_PLL: begin
                    if (r_cnt == c_rst_last) begin
                        w_nxt_state = S_WAIT_LOCK;
                    end else begin
                        w_nxt_cnt = r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        w_nxt_state = S_STABLE;
                    end else if (r_cnt == c_timeout_last) begin
                        if (r_retries == c_max_retries) begin
                            w_nxt_state = S_FAIL;
                        end else begin
                            w_nxt_state   = S_RESET_PLL;
                            w_nxt_retries = r_retries + RETRY_W'(1);
                        end
                    end else begin
                        w_nxt_cnt = r_cnt + CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    if (!w_locked_s) begin
                        w_nxt_state = S_WAIT_LOCK;
                    end else if (r_cnt == c_stable_last) begin
                        w_nxt_state   = S_RUN;
                        w_nxt_retries = '0;
                    end else begin
                        w_nxt_cnt = r_cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (!w_locked_s) begin
                        w_nxt_state = S_WAIT_LOCK;
                        if (loss_count != 8'hFF) begin
                            w_nxt_loss = loss_count + 8'd1;
                        end
                    end
                end
                S_FAIL: begin
                    w_nxt_state = S_FAIL;
                end
                default: begin
                    w_nxt_state = S_RESET_PLL;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they move with the state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state    <= S_RESET_PLL;
            r_cnt      <= '0;
            r_retries  <= '0;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            pll_rst    <= 1'b1;
            sys_rst    <= 1'b1;
            pll_ok     <= 1'b0;
            fail       <= 1'b0;
            loss_count <= 8'd0;
        end else begin
            r_sync1    <= pll_locked;
            r_sync2    <= r_sync1;
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_retries  <= w_nxt_retries;
            loss_count <= w_nxt_loss;
            pll_rst    <= (w_nxt_state == S_RESET_PLL);
            sys_rst    <= (w_nxt_state != S_RUN);
            pll_ok     <= (w_nxt_state == S_RUN);
            fail       <= (w_nxt_state == S_FAIL);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_master_clock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_master_clock_supervisor
// Brief    : Directed and randomized bench with a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_master_clock_supervisor;

    localparam int RC = 4;
    localparam int SC = 8;
    localparam int LT = 32;
    localparam int MR = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       retry = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       pll_ok;
    logic       fail;
    logic [7:0] loss_count;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;

    master_clock_supervisor #(
        .RST_CYCLES   (RC),
        .STABLE_CYCLES(SC),
        .LOCK_TIMEOUT (LT),
        .MAX_RETRIES  (MR),
        .CNT_W        (6)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .retry     (retry),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .pll_ok    (pll_ok),
        .fail      (fail),
        .loss_count(loss_count),
        .state     (state)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: time spent in each phase, attempts made, losses seen.
    int m_state = 0;
    int m_t     = 0;
    int m_tries = 0;
    int m_loss  = 0;
    bit m_d1    = 1'b0;
    bit m_d2    = 1'b0;

    always @(posedge refclk or posedge rst) begin : model
        bit ls;
        if (rst) begin
            m_state = 0; m_t = 0; m_tries = 0; m_loss = 0; m_d1 = 0; m_d2 = 0;
        end else begin
            ls = m_d2;
            if (retry && m_state != 0) begin
                m_state = 0; m_t = 0; m_tries = 0;
            end else begin
                case (m_state)
                    0: begin
                        m_t++;
                        if (m_t == RC) begin m_state = 1; m_t = 0; end
                    end
                    1: begin
                        if (ls) begin
                            m_state = 2; m_t = 0;
                        end else begin
                            m_t++;
                            if (m_t == LT) begin
                                m_t = 0;
                                if (m_tries == MR) m_state = 4;
                                else begin m_tries++; m_state = 0; end
                            end
                        end
                    end
                    2: begin
                        if (!ls) begin
                            m_state = 1; m_t = 0;
                        end else begin
                            m_t++;
                            if (m_t == SC) begin m_state = 3; m_t = 0; m_tries = 0; end
                        end
                    end
                    3: begin
                        if (!ls) begin
                            m_state = 1; m_t = 0;
                            if (m_loss < 255) m_loss++;
                        end
                    end
                    default: m_state = 4;
                endcase
            end
            m_d2 = m_d1;
            m_d1 = pll_locked;
        end
    end

    always @(negedge refclk) begin
        chk("state", int'(state), m_state);
        chk("outputs{pll_rst,sys_rst,pll_ok,fail}", int'({pll_rst, sys_rst, pll_ok, fail}),
            int'({m_state == 0, m_state != 3, m_state == 3, m_state == 4}));
        chk("loss_count", int'(loss_count), m_loss);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge refclk);
    endtask

    task automatic wait_state(input string name, input int s, input int budget, output int n);
        n = 0;
        while (int'(state) != s && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, int'(state), s);
    endtask

    task automatic count_pll_rst(input int retry_at, output int n);
        n = 0;
        while (pll_rst && n < 20) begin
            n++;
            retry = (n == retry_at);
            tick(1);
        end
        retry = 1'b0;
    endtask

    initial begin
        int n;
        int rises;
        int highs;
        bit prev;
        bit saw_wait;
        bit bad;
        int run_left;

        // Normal bring-up
        tick(3);
        chk("reset_pll_rst", int'(pll_rst), 1);
        chk("reset_sys_rst", int'(sys_rst), 1);
        rst = 1'b0;
        count_pll_rst(0, n);
        chk("bringup_pll_rst_len", n, 4);
        tick(6);
        pll_locked = 1'b1;
        wait_state("bringup_stable", 2, 20, n);
        chk("bringup_lock_latency", n, 3);
        n = 0;
        while (sys_rst && n < 30) begin tick(1); n++; end
        chk("bringup_window", n, 8);
        chk("bringup_pll_ok", int'(pll_ok), 1);
        chk("bringup_run", int'(state), 3);

        // Loss in RUN
        pll_locked = 1'b0;
        n = 0;
        while (!sys_rst && n < 10) begin tick(1); n++; end
        chk("loss_latency", n, 3);
        chk("loss_pll_ok", int'(pll_ok), 0);
        chk("loss_count_1", int'(loss_count), 1);

        // Glitch in STABLE
        pll_locked = 1'b1;
        wait_state("relock_stable", 2, 20, n);
        tick(5);
        pll_locked = 1'b0;
        saw_wait = 0;
        bad = 0;
        repeat (3) begin
            tick(1);
            if (state == 3'd1) saw_wait = 1;
            if (pll_rst || !sys_rst) bad = 1;
        end
        pll_locked = 1'b1;
        n = 0;
        while (state != 3'd2 && n < 20) begin
            tick(1); n++;
            if (state == 3'd1) saw_wait = 1;
            if (pll_rst || !sys_rst) bad = 1;
        end
        chk("glitch_saw_wait", int'(saw_wait), 1);
        chk("glitch_no_pulse_no_release", int'(bad), 0);
        n = 0;
        while (state != 3'd3 && n < 30) begin tick(1); n++; end
        chk("glitch_full_window", n, 8);

        // Retry coinciding with a loss in RUN, then retry inside RESET_PLL
        pll_locked = 1'b0;
        tick(2);
        retry = 1'b1;
        tick(1);
        retry = 1'b0;
        chk("retry_loss_state", int'(state), 0);
        chk("retry_loss_count", int'(loss_count), 1);
        count_pll_rst(2, n);
        chk("retry_in_reset_len", n, 4);
        pll_locked = 1'b1;
        wait_state("retry_relock_run", 3, 30, n);

        // 300 losses saturate the counter
        repeat (300) begin
            pll_locked = 1'b0;
            tick(4);
            pll_locked = 1'b1;
            tick(12);
        end
        chk("loss_saturate", int'(loss_count), 255);

        // Async reset in STABLE at cnt 5
        pll_locked = 1'b0;
        tick(4);
        pll_locked = 1'b1;
        wait_state("async_stable", 2, 20, n);
        tick(5);
        #2 rst = 1'b1;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_outs", int'({pll_rst, sys_rst, pll_ok, fail}), 4'b1100);
        chk("async_loss", int'(loss_count), 0);
        tick(2);

        // Never lock: three pulses then FAIL
        pll_locked = 1'b0;
        rst = 1'b0;
        n = 0; rises = 1; highs = 0; prev = 1;
        while (!fail && n < 300) begin
            if (pll_rst) highs++;
            if (pll_rst && !prev) rises++;
            prev = pll_rst;
            tick(1); n++;
        end
        chk("nolock_cycles_to_fail", n, 3 * (RC + LT));
        chk("nolock_pulses", rises, 3);
        chk("nolock_pulse_cycles", highs, 12);
        bad = 0;
        repeat (20) begin
            tick(1);
            if (state != 3'd4 || pll_rst || !sys_rst || !fail) bad = 1;
        end
        chk("fail_steady", int'(bad), 0);

        // Retry out of FAIL
        retry = 1'b1;
        tick(1);
        retry = 1'b0;
        chk("fail_retry_clears", int'(fail), 0);
        count_pll_rst(0, n);
        chk("fail_retry_pulse_len", n, 4);
        pll_locked = 1'b1;
        wait_state("fail_retry_run", 3, 40, n);

        // Randomized lock activity with sporadic retries
        run_left = 0;
        repeat (3000) begin
            if (run_left == 0) begin
                pll_locked = ~pll_locked;
                run_left = pll_locked ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 12));
            end
            run_left--;
            retry = ($urandom_range(0, 63) == 0);
            tick(1);
        end
        retry = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
